// File: rtl/mlp_pkg.sv
// mlp_pkg: activation encodings, FSM states and fixed-point defaults
// shared by the layer engine and its activation unit.
package mlp_pkg;

  localparam int RES_DEF  = 8;
  localparam int FRAC_DEF = 4;

  typedef enum logic [1:0] {
    ACT_ID   = 2'd0,
    ACT_RELU = 2'd1,
    ACT_HSIG = 2'd2,
    ACT_RSV  = 2'd3
  } act_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_FLUSH,
    ST_OUT
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_layer_engine_act_unit.sv
// act_unit: round/saturate accumulator to RES bits, then activation.
// Ports: acc_i accumulator, mode_i activation select, y_o result.
module act_unit
  import mlp_pkg::*;
#(
  parameter int RES   = RES_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = 2*RES_DEF + 11
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  act_mode_e               mode_i,
  output logic signed [RES-1:0]   y_o
);

  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'(2**(FRAC-1));
  localparam logic signed [ACC_W:0] ZMAX =
    (ACC_W+1)'(2**(RES-1)-1);
  localparam logic signed [ACC_W:0] ZMIN = ~ZMAX;
  localparam logic signed [RES:0] HALF =
    (RES+1)'(2**(FRAC-1));
  localparam logic signed [RES:0] ONE =
    (RES+1)'(2**FRAC);

  logic signed [ACC_W:0] t;
  logic signed [ACC_W:0] s;
  logic signed [RES-1:0] z;
  logic signed [RES:0]   zx;
  logic signed [RES:0]   h;

  always_comb begin
    // one guard bit so the rounding add cannot wrap
    t = {acc_i[ACC_W-1], acc_i} + RND;
    s = t >>> FRAC;
    unique case (1'b1)
      (s > ZMAX): z = {1'b0, {(RES-1){1'b1}}};
      (s < ZMIN): z = {1'b1, {(RES-1){1'b0}}};
      default:    z = s[RES-1:0];
    endcase
    zx  = {z[RES-1], z};
    h   = (zx >>> 2) + HALF;
    y_o = z;
    unique case (mode_i)
      ACT_RELU: y_o = z[RES-1] ? '0 : z;
      ACT_HSIG: begin
        if (h < 0)        y_o = '0;
        else if (h > ONE) y_o = ONE[RES-1:0];
        else              y_o = h[RES-1:0];
      end
      default:  y_o = z;
    endcase
  end

endmodule

// File: rtl/mac_layer_engine.sv
// mac_layer_engine: streams in N_IN samples, runs N_OUT neurons
// against weight/bias ROMs and streams out activated results.
// Ports: clk/reset, start/busy/done job control, act_mode,
// in_* input stream, w_*/b_* ROM ports, out_* result stream.
module mac_layer_engine
  import mlp_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_OUT = 30,
  parameter int RES   = RES_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = 2*RES + $clog2(N_IN) + 1,
  localparam int WA_W = clog2_min1(N_IN*N_OUT),
  localparam int BA_W = clog2_min1(N_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [1:0]            act_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [RES-1:0] in_data,
  output logic [WA_W-1:0]       w_addr,
  input  logic signed [RES-1:0] w_data,
  output logic [BA_W-1:0]       b_addr,
  input  logic signed [RES-1:0] b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [RES-1:0] out_data,
  output logic [BA_W-1:0]       out_index
);

  localparam int IW = clog2_min1(N_IN);
  localparam logic [IW-1:0]   I_LAST = IW'(N_IN-1);
  localparam logic [BA_W-1:0] J_LAST = BA_W'(N_OUT-1);

  state_e    state_q;
  act_mode_e mode_q;

  logic [IW-1:0]   i_q;
  logic [IW-1:0]   idx1_q;
  logic [BA_W-1:0] j_q;
  logic            vld1_q;
  logic            first1_q;
  logic            done_q;
  logic            out_valid_q;
  logic [WA_W-1:0] w_addr_q;
  logic [BA_W-1:0] b_addr_q;

  logic signed [RES-1:0]   out_data_q;
  logic signed [RES-1:0]   x_q [N_IN];
  logic signed [RES-1:0]   act_y;
  logic signed [2*RES-1:0] prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] bias_x;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // ROM data lags its address by one cycle, so the
  // accumulate side runs on the delayed idx1/first1/vld1.
  always_comb begin
    prod   = x_q[idx1_q] * w_data;
    prod_x = ACC_W'(prod);
    bias_x = ACC_W'(b_data) <<< FRAC;
    base   = first1_q ? bias_x : acc_q;
    acc_d  = vld1_q ? base + prod_x : acc_q;
  end

  act_unit #(
    .RES   (RES),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_act (
    .acc_i  (acc_d),
    .mode_i (mode_q),
    .y_o    (act_y)
  );

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && in_valid)
      x_q[i_q] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= ACT_ID;
      i_q         <= '0;
      j_q         <= '0;
      idx1_q      <= '0;
      vld1_q      <= 1'b0;
      first1_q    <= 1'b0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      acc_q    <= acc_d;
      vld1_q   <= (state_q == ST_MAC);
      first1_q <= (state_q == ST_MAC) && (i_q == '0);
      idx1_q   <= i_q;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= act_mode_e'(act_mode);
            i_q     <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (i_q == I_LAST) begin
              i_q      <= '0;
              j_q      <= '0;
              w_addr_q <= '0;
              b_addr_q <= '0;
              state_q  <= ST_MAC;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end
        end
        ST_MAC: begin
          if (i_q == I_LAST) begin
            state_q <= ST_FLUSH;
          end else begin
            i_q      <= i_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          // acc_d already holds the final sum here
          out_data_q  <= act_y;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (j_q == J_LAST) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              // last addr + 1 is the next row base
              j_q      <= j_q + 1'b1;
              b_addr_q <= b_addr_q + 1'b1;
              w_addr_q <= w_addr_q + 1'b1;
              i_q      <= '0;
              state_q  <= ST_MAC;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign in_ready  = (state_q == ST_LOAD);
  assign w_addr    = w_addr_q;
  assign b_addr    = b_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = j_q;

endmodule

// File: tb/tb_mac_layer_engine.sv
// tb_mac_layer_engine: scoreboard bench for mac_layer_engine
// with small ROM models and an integer reference model.
module tb_mac_layer_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int RES   = 8;
  localparam int FRAC  = 4;
  localparam int WA    = $clog2(N_IN*N_OUT);
  localparam int BA    = $clog2(N_OUT);

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic start     = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b1;
  logic [1:0] act_mode = 2'd0;
  logic busy, done, in_ready, out_valid;
  logic signed [RES-1:0] in_data = '0;
  logic signed [RES-1:0] w_data, b_data, out_data;
  logic [WA-1:0] w_addr;
  logic [BA-1:0] b_addr, out_index;

  logic signed [RES-1:0] w_mem [N_IN*N_OUT];
  logic signed [RES-1:0] b_mem [N_OUT];
  logic signed [RES-1:0] xv [N_IN];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_q [$];
  int idx_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= w_mem[w_addr];
    b_data <= b_mem[b_addr];
  end

  mac_layer_engine #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .RES   (RES),
    .FRAC  (FRAC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .act_mode  (act_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index)
  );

  task automatic set_vec(input int x, input int w, input int b);
    for (int i = 0; i < N_IN; i++) xv[i] = RES'(x);
    for (int i = 0; i < N_IN*N_OUT; i++) w_mem[i] = RES'(w);
    for (int j = 0; j < N_OUT; j++) b_mem[j] = RES'(b);
  endtask

  function automatic int model(input int j, input int mode);
    int acc, z, h;
    acc = b_mem[j];
    acc = acc * (1 << FRAC);
    for (int i = 0; i < N_IN; i++)
      acc += int'(xv[i]) * int'(w_mem[j*N_IN+i]);
    z = (acc + (1 << (FRAC-1))) >>> FRAC;
    if (z > 127) z = 127;
    if (z < -128) z = -128;
    if (mode == 1) return (z < 0) ? 0 : z;
    if (mode == 2) begin
      h = (z >>> 2) + (1 << (FRAC-1));
      if (h < 0) h = 0;
      if (h > (1 << FRAC)) h = 1 << FRAC;
      return h;
    end
    return z;
  endfunction

  task automatic run_job(input int mode, input int stall,
                         input bit rnd);
    int k, g, nout, last_hs, e, ei;
    logic signed [RES-1:0] d;
    logic [BA-1:0] ix;
    logic [WA-1:0] wa;
    @(negedge clk);
    act_mode = mode[1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    act_mode = 2'd0;
    k = 0;
    g = 0;
    while (k < N_IN && g < 200) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = xv[k];
      if (rnd) start = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) k++;
      g++;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = rnd;
    in_data = RES'($urandom);
    n_chk++;
    if (k != N_IN || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load: taken %0d in_ready %b want %0d/0",
               k, in_ready, N_IN);
    end
    out_ready = (stall == 0);
    nout = 0;
    g = 0;
    last_hs = -1;
    while (nout < N_OUT && g < 500) begin
      n_chk++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL early_done: done %b want 0", done);
      end
      if (out_valid === 1'b1) begin
        if (stall > 0 && !out_ready) begin
          d = out_data;
          ix = out_index;
          wa = w_addr;
          repeat (stall) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== d ||
                out_index !== ix || w_addr !== wa) begin
              n_fail++;
              $display("FAIL stall: v%b d%0d i%0d a%0d want 1 %0d %0d %0d",
                       out_valid, out_data, out_index, w_addr,
                       d, ix, wa);
            end
          end
          out_ready = 1'b1;
        end
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_out: data %0d idx %0d want none",
                   out_data, out_index);
        end else begin
          e = exp_q.pop_front();
          ei = idx_q.pop_front();
          if (out_data !== RES'(e) || out_index !== BA'(ei)) begin
            n_fail++;
            $display("FAIL out: data %0d idx %0d want %0d %0d",
                     out_data, out_index, e, ei);
          end
        end
        if (last_hs >= 0) begin
          n_chk++;
          if (cyc - last_hs != N_IN + 2) begin
            n_fail++;
            $display("FAIL period: got %0d want %0d",
                     cyc - last_hs, N_IN + 2);
          end
        end
        last_hs = cyc;
        nout++;
      end
      g++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (nout != N_OUT || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done: beats %0d done %b busy %b want %0d 1 0",
               nout, done, busy, N_OUT);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_pulse: done %b left %0d want 0 0",
               done, exp_q.size());
    end
  endtask

  task automatic push2(input int e0, input int e1);
    exp_q.push_back(e0);
    idx_q.push_back(0);
    exp_q.push_back(e1);
    idx_q.push_back(1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, in_ready, out_valid, out_data,
         out_index, w_addr, b_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset: b%b d%b r%b v%b o%0d i%0d wa%0d ba%0d want 0",
               busy, done, in_ready, out_valid, out_data,
               out_index, w_addr, b_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_vec(16, 16, 0);
    push2(64, 64);
    run_job(0, 0, 1'b0);
  endtask

  task automatic test_saturate();
    set_vec(127, 127, 127);
    push2(127, 127);
    run_job(0, 0, 1'b0);
    set_vec(127, -128, 127);
    push2(-128, -128);
    run_job(0, 0, 1'b0);
  endtask

  task automatic test_activation();
    set_vec(16, -16, 0);
    push2(0, 0);
    run_job(1, 0, 1'b0);
    push2(0, 0);
    run_job(2, 0, 1'b0);
    set_vec(16, 0, 0);
    push2(8, 8);
    run_job(2, 0, 1'b0);
    set_vec(16, 16, 0);
    push2(16, 16);
    run_job(2, 0, 1'b0);
    push2(64, 64);
    run_job(3, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    set_vec(16, 16, 0);
    for (int i = N_IN; i < 2*N_IN; i++) w_mem[i] = 8'sd8;
    push2(64, 32);
    run_job(0, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    int g;
    set_vec(16, 16, 0);
    for (int i = N_IN; i < 2*N_IN; i++) w_mem[i] = 8'sd8;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      in_data = xv[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    g = 0;
    while (out_valid !== 1'b1 && g < 50) begin
      g++;
      @(negedge clk);
    end
    n_chk++;
    if (out_data !== 8'sd64 || out_index !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_n0: data %0d idx %0d want 64 0",
               out_data, out_index);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || out_valid !== 1'b0 ||
        out_index !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_state: busy %b v %b idx %0d want 1 0 1",
               busy, out_valid, out_index);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, in_ready, out_valid, out_data,
         out_index, w_addr, b_addr} !== '0) begin
      n_fail++;
      $display("FAIL rm_reset: b%b d%b v%b o%0d i%0d wa%0d want 0",
               busy, done, out_valid, out_data, out_index, w_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (N_IN + 4) begin
      @(negedge clk);
      n_chk++;
      if ({done, out_valid, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rm_quiet: done %b v %b busy %b want 0",
                 done, out_valid, busy);
      end
    end
    push2(64, 32);
    run_job(0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N_IN; i++) xv[i] = RES'($urandom);
      for (int i = 0; i < N_IN*N_OUT; i++)
        w_mem[i] = RES'($urandom);
      for (int j = 0; j < N_OUT; j++) b_mem[j] = RES'($urandom);
      for (int j = 0; j < N_OUT; j++) begin
        exp_q.push_back(model(j, it % 4));
        idx_q.push_back(j);
      end
      run_job(it % 4, 0, 1'b1);
    end
  endtask

  initial begin
    set_vec(0, 0, 0);
    test_reset();
    test_basic();
    test_saturate();
    test_activation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_layer_engine.md
MAC_LAYER_ENGINE -- requirements
Module: mac_layer_engine

Interface
REQ-001 SHALL have parameter N_IN, default 784: input vector length.
REQ-002 SHALL have parameter N_OUT, default 30: neuron count.
REQ-003 SHALL have parameter RES, default 8: signed data, weight, bias and output width.
REQ-004 SHALL have parameter FRAC, default 4: fractional bits of all fixed-point values; legal range 1..RES-2.
REQ-005 SHALL have parameter ACC_W, default 2*RES+clog2(N_IN)+1: accumulator width.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have ports start (input, 1), busy (output, 1) and done (output, 1): job control.
REQ-009 SHALL have port act_mode, input, 2: 0 identity, 1 ReLU, 2 hard-sigmoid, 3 reserved and treated as identity.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, RES, signed): input-vector stream.
REQ-011 SHALL have ports w_addr (output, clog2(N_IN*N_OUT)) and w_data (input, RES, signed): weight ROM read port with 1-cycle read latency.
REQ-012 SHALL have ports b_addr (output, clog2(N_OUT)) and b_data (input, RES, signed): bias ROM read port with 1-cycle read latency.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, RES, signed) and out_index (output, clog2(N_OUT)): result stream.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, MAC, FLUSH and OUT.
REQ-015 SHALL, in IDLE, move to LOAD on start=1 and latch act_mode; start SHALL be ignored in every other state.
REQ-016 SHALL, in LOAD, hold in_ready=1 and store one sample per in_valid&in_ready cycle into x buffer index 0..N_IN-1; after the N_IN-th sample it SHALL move to MAC with neuron j=0.
REQ-017 SHALL hold in_ready=0 outside LOAD; in_valid outside LOAD SHALL have no effect.
REQ-018 SHALL, in MAC, issue w_addr=j*N_IN+i for i=0..N_IN-1, one per cycle, and issue b_addr=j in the cycle i=0.
REQ-019 SHALL initialise the accumulator to sign-extended b_data<<<FRAC and add x[i]*w_data (full-precision signed product) one cycle after each address.
REQ-020 SHALL spend one FLUSH cycle after the last address so the final product is accumulated, then enter OUT.
REQ-021 SHALL compute z = (acc + 2^(FRAC-1)) >>> FRAC, saturated to [-2^(RES-1), 2^(RES-1)-1].
REQ-022 SHALL apply the activation to z: identity gives z; ReLU gives max(z,0); hard-sigmoid gives clamp((z>>>2)+2^(FRAC-1), 0, 2^FRAC).
REQ-023 SHALL, in OUT, assert out_valid with out_data and out_index=j held stable until out_ready=1.
REQ-024 SHALL, on the out handshake, start MAC for j+1 if j<N_OUT-1; otherwise it SHALL pulse done for 1 cycle and return to IDLE.
REQ-025 SHALL give a minimum neuron period of N_IN+2 cycles; out_ready low SHALL only stretch OUT.
REQ-026 SHALL hold busy=1 in every state except IDLE.
REQ-027 SHALL keep the accumulator from overflowing for any inputs, given ACC_W.

Reset
REQ-028 SHALL, on reset, immediately force IDLE and drive busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_index=0, w_addr=0 and b_addr=0.
REQ-029 SHALL abandon any job in progress on reset, emit no further out beats and no done, and accept a new start in the first cycle after reset deasserts.
REQ-030 SHALL leave the x buffer contents undefined after reset and SHALL NOT reset it.

Structure
REQ-031 SHALL place act_mode encodings, FSM state typedef and default RES/FRAC constants in shared package mlp_pkg.
REQ-032 SHALL implement requantisation plus activation (REQ-021/022) as the combinational sub-module act_unit.

Verification (N_IN=4, N_OUT=2, RES=8, FRAC=4 unless stated)
REQ-033 SHALL cover this case: x all 16, weights all 16, bias 0, mode 0 -> out 64 at index 0 and 1, then a done pulse.
REQ-034 SHALL cover this case: x all 127, weights all 127, bias 127, mode 0 -> out 127 (saturated); with weights all -128 -> -128.
REQ-035 SHALL cover this case: x all 16, weights all -16, bias 0, mode 1 -> 0; mode 2 -> 0; bias 0 and weights 0 with mode 2 -> 8; z=64 with mode 2 -> 16.
REQ-036 SHALL cover this case: out_ready low for 5 cycles at neuron 0 -> out_valid/data/index stable, no w_addr advance, both outputs correct.
REQ-037 SHALL cover this case: reset asserted during MAC of neuron 1 -> all outputs zero same cycle, no done; a following start runs to completion correctly.
REQ-038 SHALL cover this case: in_valid toggling randomly during LOAD and start pulsed while busy -> exactly N_IN samples taken, start ignored, results match the reference model.
